diff_add_mul_gen: RTL and testbench
===================================

DIFF_ADD_MUL_GEN -- requirements
Module: diff_add_mul_gen

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal values are 4 or more and a multiple of MUL_RADIX.
REQ-002 Parameter MUL_RADIX, default 4: multiplier bits retired per multiply cycle; legal values are 1, 2, 4 or 8, and MUL_RADIX SHALL divide WIDTH.
REQ-003 clk  input  1  the single clock; all logic is rising-edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i, j, k  input  WIDTH each  unsigned operands.
REQ-006 operation  input  1  1 = add, 0 = multiply.
REQ-007 in_valid  input  1  operand set presented.
REQ-008 in_ready  output  1  block can accept an operand set.
REQ-009 vo  output  WIDTH  result.
REQ-010 neg  output  1  1 when i < j for the reported result.
REQ-011 ovf  output  1  1 when the true result exceeds 2^WIDTH-1.
REQ-012 out_valid  output  1  vo, neg and ovf are valid.
REQ-013 out_ready  input  1  consumer accepts the result.

Function
REQ-014 Accept: the operand set is captured on a rising edge where in_valid=1 and in_ready=1.
REQ-015 Result: d = |i-j|, computed at WIDTH+1 bits; the result is d+k when operation=1 and d*k when operation=0.
REQ-016 States are IDLE, ABS, ADD, MUL and OUT; the state after reset is IDLE.
REQ-017 in_ready SHALL be 1 only in IDLE.
REQ-018 An accept moves IDLE to ABS; in IDLE, in_valid=0 keeps the block in IDLE.
REQ-019 ABS registers d and neg, then moves to ADD if operation=1, else to MUL.
REQ-020 ADD computes the WIDTH+1-bit sum in one cycle, then moves to OUT.
REQ-021 MUL retires MUL_RADIX bits of k per cycle, LSB first, accumulating the shifted d*digit into a 2*WIDTH-bit product.
REQ-022 MUL moves to OUT on the cycle the remaining unshifted k bits are all zero, so it occupies 1 to WIDTH/MUL_RADIX cycles; k=0 takes 1 cycle.
REQ-023 Add latency: out_valid rises 3 cycles after the accept edge.
REQ-024 Multiply latency: out_valid rises 2+N cycles after the accept edge, where N = MUL cycles.
REQ-025 OUT drives out_valid=1 and holds vo, neg and ovf stable until an edge with out_ready=1, then moves to IDLE.
REQ-026 There is no same-cycle turnaround: in the OUT handshake cycle in_ready=0, and the next accept happens no earlier than the following cycle.
REQ-027 vo, neg and ovf are 0 whenever out_valid=0.
REQ-028 ovf = 1 when the upper bits of the sum (bit WIDTH) or of the product (bits 2*WIDTH-1..WIDTH) are nonzero.
REQ-029 i=j gives d=0 and neg=0.
REQ-030 in_valid and operands are ignored outside IDLE.
REQ-031 Changes on out_ready outside OUT have no effect.

Reset
REQ-032 rst=1 at an edge SHALL force IDLE and clear every register, including operands, d and the product, regardless of the current state, including mid-MUL.
REQ-033 On the cycle after reset, out_valid=0, vo=0, neg=0, ovf=0 and in_ready=1.
REQ-034 An accept in the same cycle as rst=1 is discarded.

Configuration
REQ-035 Macro DIFF_ADD_MUL_SAT_EN, when defined: when ovf=1, vo SHALL be all ones (2^WIDTH-1).
REQ-036 Without DIFF_ADD_MUL_SAT_EN: vo is the result truncated modulo 2^WIDTH.
REQ-037 ovf, neg and latency are identical with or without DIFF_ADD_MUL_SAT_EN.

Verification (WIDTH=8, MUL_RADIX=4, out_ready=1 unless stated)
REQ-038 i=5, j=9, k=3, operation=1 -> vo=7, neg=1, ovf=0; out_valid rises 3 cycles after accept.
REQ-039 i=20, j=4, k=3, operation=0 -> vo=48, neg=0, ovf=0; MUL takes 1 cycle; out_valid rises 3 cycles after accept.
REQ-040 i=0x30, j=0, k=0x12, operation=0 -> product 0x360, ovf=1; MUL takes 2 cycles (latency 4); vo=0x60, or 0xFF with DIFF_ADD_MUL_SAT_EN.
REQ-041 i=200, j=0, k=100, operation=1 -> ovf=1; vo=44, or 255 with DIFF_ADD_MUL_SAT_EN.
REQ-042 Hold out_ready=0 for 5 cycles in OUT -> vo and flags stay stable and in_ready=0; raising out_ready gives one handshake, then in_ready=1 on the next cycle.
REQ-043 Assert rst during the 2nd MUL cycle of REQ-040 -> the next cycle shows out_valid=0, vo=0, in_ready=1, and no result is ever emitted for that operand set.

Source files
------------

// File: rtl/diff_add_mul_gen.sv
// Computes |i-j| then either adds k or multiplies by k (radix-MUL_RADIX iterative), with valid/ready handshakes.
// Optional macro DIFF_ADD_MUL_SAT_EN saturates vo to all ones on overflow.
module diff_add_mul_gen #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MUL_RADIX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             operation,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] vo,
  output logic             neg,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS,
    S_ADD,
    S_MUL,
    S_OUT
  } state_t;

  state_t               r_state;
  logic                 r_op;
  logic [WIDTH-1:0]     r_i;
  logic [WIDTH-1:0]     r_j;
  logic [WIDTH-1:0]     r_k;
  logic [DW-1:0]        r_d;
  logic                 r_neg;
  logic [PW-1:0]        r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [PW-1:0]        r_res;
  logic                 r_in_ready;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_vo;
  logic                 r_neg_o;
  logic                 r_ovf;

  logic                 w_neg;
  logic [DW-1:0]        w_d;
  logic [PW-1:0]        w_sum;
  logic [MUL_RADIX-1:0] w_digit;
  logic [PW-1:0]        w_pp;
  logic [WIDTH-1:0]     w_rest;
  logic                 w_ovf;
  logic [WIDTH-1:0]     w_vo;

  // Datapath: absolute difference, sum, one radix digit of the product
  assign w_neg   = (r_i < r_j);
  assign w_d     = w_neg ? (DW'(r_j) - DW'(r_i)) : (DW'(r_i) - DW'(r_j));
  assign w_sum   = PW'(r_d) + PW'(r_k);
  assign w_digit = r_mplier[MUL_RADIX-1:0];
  assign w_pp    = r_mcand * PW'(w_digit);
  assign w_rest  = r_mplier >> MUL_RADIX;
  assign w_ovf   = |r_res[PW-1:WIDTH];

`ifdef DIFF_ADD_MUL_SAT_EN
  assign w_vo = w_ovf ? '1 : r_res[WIDTH-1:0];
`else
  assign w_vo = r_res[WIDTH-1:0];
`endif

  // Control FSM; OUT spends its first cycle loading the output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= 1'b0;
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_d         <= '0;
      r_neg       <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_vo        <= '0;
      r_neg_o     <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_i        <= i;
            r_j        <= j;
            r_k        <= k;
            r_op       <= operation;
            r_in_ready <= 1'b0;
            r_state    <= S_ABS;
          end
        end
        S_ABS: begin
          r_d      <= w_d;
          r_neg    <= w_neg;
          r_mcand  <= PW'(w_d);
          r_mplier <= r_k;
          r_res    <= '0;
          r_state  <= r_op ? S_ADD : S_MUL;
        end
        S_ADD: begin
          r_res   <= w_sum;
          r_state <= S_OUT;
        end
        S_MUL: begin
          r_res    <= r_res + w_pp;
          r_mcand  <= r_mcand << MUL_RADIX;
          r_mplier <= w_rest;
          if (w_rest == '0) begin
            r_state <= S_OUT;
          end
        end
        S_OUT: begin
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_vo        <= w_vo;
            r_neg_o     <= r_neg;
            r_ovf       <= w_ovf;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
            r_vo        <= '0;
            r_neg_o     <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign vo        = r_vo;
  assign neg       = r_neg_o;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_diff_add_mul_gen.sv
// Self-checking bench for diff_add_mul_gen: directed literal cases plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_diff_add_mul_gen;

  localparam int unsigned W = 8;
  localparam int unsigned R = 4;
  localparam longint MAXV = (longint'(1) << W) - 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] i, j, k;
  logic         operation;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] vo;
  logic         neg;
  logic         ovf;
  logic         out_valid;
  logic         out_ready;

  int checks = 0;
  int errors = 0;

  diff_add_mul_gen #(.WIDTH(W), .MUL_RADIX(R)) dut (
    .clk(clk), .rst(rst), .i(i), .j(j), .k(k), .operation(operation),
    .in_valid(in_valid), .in_ready(in_ready), .vo(vo), .neg(neg), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level result: value, flags and cycles from accept to out_valid
  function automatic void model_calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] c, input logic op,
                                     output logic [W-1:0] evo, output logic eneg,
                                     output logic eovf, output int unsigned elat);
    longint d, res;
    int unsigned n;
    d    = (a >= b) ? longint'(a) - longint'(b) : longint'(b) - longint'(a);
    res  = op ? d + longint'(c) : d * longint'(c);
    eneg = (a < b);
    eovf = (res > MAXV);
`ifdef DIFF_ADD_MUL_SAT_EN
    evo  = eovf ? '1 : res[W-1:0];
`else
    evo  = res[W-1:0];
`endif
    n = 1;
    while ((longint'(c) >> (n * R)) != 0) n++;
    elat = op ? 3 : 2 + n;
  endfunction

  // Model state: busy with one transaction whose output appears at edge m_rise
  int unsigned  edges = 0;
  bit           m_known = 0;
  bit           m_busy = 0;
  int unsigned  m_rise = 0;
  logic [W-1:0] m_vo = '0;
  logic         m_neg = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin : model
    bit vis;
    int unsigned lat;
    vis = m_busy && (edges >= m_rise);
    edges++;
    if (rst) begin
      m_known = 1;
      m_busy  = 0;
    end else if (m_known) begin
      if (!m_busy) begin
        if (in_valid) begin
          model_calc(i, j, k, operation, m_vo, m_neg, m_ovf, lat);
          m_busy = 1;
          m_rise = edges + lat;
        end
      end else if (vis && out_ready) begin
        m_busy = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic ev;
    if (m_known) begin
      ev = m_busy && (edges >= m_rise);
      chk("cycle", {51'd0, in_ready, out_valid, neg, ovf, vo},
          {51'd0, !m_busy, ev, ev & m_neg, ev & m_ovf, ev ? m_vo : 8'd0});
    end
  end

  task automatic txn(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] c, input logic op, input logic [W-1:0] evo,
                     input logic eneg, input logic eovf, input int elat, input int hold);
    int n;
    int lat;
    out_ready = (hold == 0);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " in_ready"}, 64'(in_ready), 64'd1);
    i = a; j = b; k = c; operation = op; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    i = W'($urandom); j = W'($urandom); k = W'($urandom); operation = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, " latency"}, 64'(lat), 64'(elat));
    chk({name, " result"}, {54'd0, neg, ovf, vo}, {54'd0, eneg, eovf, evo});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, " hold"}, {53'd0, in_ready, out_valid, neg, ovf, vo},
          {53'd0, 1'b0, 1'b1, eneg, eovf, evo});
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, " release"}, {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin : driver
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    i = '0; j = '0; k = '0; operation = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset state", {53'd0, in_ready, out_valid, neg, ovf, vo}, {53'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});
    rst = 1'b0;
    @(negedge clk);

    txn("add_neg",   8'd5,    8'd9, 8'd3,    1'b1, 8'd7,  1'b1, 1'b0, 3, 0);
    txn("mul_1cyc",  8'd20,   8'd4, 8'd3,    1'b0, 8'd48, 1'b0, 1'b0, 3, 0);
`ifdef DIFF_ADD_MUL_SAT_EN
    txn("mul_ovf",   8'h30,   8'd0, 8'h12,   1'b0, 8'hFF, 1'b0, 1'b1, 4, 0);
    txn("add_ovf",   8'd200,  8'd0, 8'd100,  1'b1, 8'd255, 1'b0, 1'b1, 3, 0);
    txn("mul_max",   8'd255,  8'd0, 8'd255,  1'b0, 8'hFF, 1'b0, 1'b1, 4, 0);
`else
    txn("mul_ovf",   8'h30,   8'd0, 8'h12,   1'b0, 8'h60, 1'b0, 1'b1, 4, 0);
    txn("add_ovf",   8'd200,  8'd0, 8'd100,  1'b1, 8'd44, 1'b0, 1'b1, 3, 0);
    txn("mul_max",   8'd255,  8'd0, 8'd255,  1'b0, 8'h01, 1'b0, 1'b1, 4, 0);
`endif
    txn("i_eq_j",    8'd7,    8'd7, 8'd9,    1'b1, 8'd9,  1'b0, 1'b0, 3, 0);
    txn("mul_k0",    8'd100,  8'd3, 8'd0,    1'b0, 8'd0,  1'b0, 1'b0, 3, 0);
    txn("hold5",     8'd3,    8'd10, 8'd5,   1'b0, 8'd35, 1'b1, 1'b0, 3, 5);

    // Reset during the second MUL cycle: the operand set must vanish
    i = 8'h30; j = 8'd0; k = 8'h12; operation = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_mul reset", {54'd0, in_ready, out_valid, vo}, {54'd0, 1'b1, 1'b0, 8'd0});
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_mul no output", 64'(seen), 64'd0);

    // Accept coincident with reset is discarded
    i = 8'd1; j = 8'd2; k = 8'd3; operation = 1'b1; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid || !in_ready) seen++;
    end
    chk("accept under reset", 64'(seen), 64'd0);

    // Randomized traffic with back-pressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      i         = W'($urandom);
      j         = W'($urandom);
      k         = ($urandom_range(0, 1) != 0) ? W'($urandom_range(0, 15)) : W'($urandom);
      operation = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (30) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
